sap1_datapath: RTL and testbench

SAP-1 datapath: the block directly downstream of the controller. It consumes the 12-bit control word and implements the shared 8-bit bus, program counter, memory address register, 16x8 RAM, instruction register, A and B registers, the adder/subtractor and the halt latch. It returns the instruction opcode to the controller and exposes internal state for observation. It also provides a program-load port so a bench or loader can write the RAM.

---
 rtl/sap1_datapath.sv | 142 ++++++++++++++
 tb/tb_sap1_datapath.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: shared bus, PC, MAR, 16x8 RAM, IR, A/B registers,
// adder/subtractor, sticky halt and bus-conflict flags, plus a RAM
// program-load port that stays live through reset and halt.
module sap1_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       ctrl,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [3:0]        opcode,
    output logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              carry,
    output logic              halted,
    output logic              bus_conflict
);

    localparam int                RAM_D  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] A_ZERO = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};

    // Control word decode
    logic w_hlt, w_pc_inc, w_pc_en, w_mem_load, w_mem_en, w_ir_load;
    logic w_ir_en, w_a_load, w_a_en, w_b_load, w_adder_sub, w_adder_en;

    assign w_hlt       = ctrl[11];
    assign w_pc_inc    = ctrl[10];
    assign w_pc_en     = ctrl[9];
    assign w_mem_load  = ctrl[8];
    assign w_mem_en    = ctrl[7];
    assign w_ir_load   = ctrl[6];
    assign w_ir_en     = ctrl[5];
    assign w_a_load    = ctrl[4];
    assign w_a_en      = ctrl[3];
    assign w_b_load    = ctrl[2];
    assign w_adder_sub = ctrl[1];
    assign w_adder_en  = ctrl[0];

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_carry;
    logic              r_halted;
    logic              r_bus_conflict;
    logic [DATA_W-1:0] r_ram [0:RAM_D-1];

    logic [DATA_W:0]   w_sum_ext;
    logic [DATA_W-1:0] w_bus;
    logic [2:0]        w_en_cnt;
    logic              w_conflict;

    // Adder/subtractor; the extra top bit is carry for ADD and borrow for SUB
    always_comb begin
        w_sum_ext = {1'b0, D_ZERO};
        if (w_adder_sub) begin
            w_sum_ext = {1'b0, r_a} - {1'b0, r_b};
        end else begin
            w_sum_ext = {1'b0, r_a} + {1'b0, r_b};
        end
    end

    // Bus mux with fixed driver priority; RAM read is asynchronous from MAR
    always_comb begin
        w_bus = D_ZERO;
        if (w_adder_en) begin
            w_bus = w_sum_ext[DATA_W-1:0];
        end else if (w_a_en) begin
            w_bus = r_a;
        end else if (w_ir_en) begin
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_ir[ADDR_W-1:0]};
        end else if (w_mem_en) begin
            w_bus = r_ram[r_mar];
        end else if (w_pc_en) begin
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, r_pc};
        end else begin
            w_bus = D_ZERO;
        end
    end

    // Count requested bus drivers to flag contention
    always_comb begin
        w_en_cnt = {2'b00, w_adder_en} + {2'b00, w_a_en} + {2'b00, w_ir_en}
                 + {2'b00, w_mem_en} + {2'b00, w_pc_en};
        if (w_en_cnt >= 3'd2) begin
            w_conflict = 1'b1;
        end else begin
            w_conflict = 1'b0;
        end
    end

    // Program-load write port; independent of reset and halt, RAM never cleared
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_ram[prog_addr] <= prog_data;
        end
    end

    // Register updates: reset clears all, halt freezes all, otherwise ctrl-driven
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc           <= A_ZERO;
            r_mar          <= A_ZERO;
            r_ir           <= D_ZERO;
            r_a            <= D_ZERO;
            r_b            <= D_ZERO;
            r_carry        <= 1'b0;
            r_halted       <= 1'b0;
            r_bus_conflict <= 1'b0;
        end else if (!r_halted) begin
            if (w_pc_inc)   r_pc  <= r_pc + PC_ONE;
            if (w_mem_load) r_mar <= w_bus[ADDR_W-1:0];
            if (w_ir_load)  r_ir  <= w_bus;
            if (w_a_load) begin
                r_a <= w_bus;
                if (w_adder_en) r_carry <= w_sum_ext[DATA_W];
            end
            if (w_b_load)   r_b            <= w_bus;
            if (w_hlt)      r_halted       <= 1'b1;
            if (w_conflict) r_bus_conflict <= 1'b1;
        end
    end

    assign bus          = w_bus;
    assign opcode       = r_ir[DATA_W-1 -: 4];
    assign pc_out       = r_pc;
    assign a_out        = r_a;
    assign b_out        = r_b;
    assign carry        = r_carry;
    assign halted       = r_halted;
    assign bus_conflict = r_bus_conflict;

endmodule

// File: tb/tb_sap1_datapath.sv
// Table-driven bench for sap1_datapath: each record gives the inputs for one
// cycle, the bus value expected before the edge and the register state
// expected after it. Register expectations travel through a scoreboard queue.
module tb_sap1_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ctrl = 12'h000;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'h0;
    logic [7:0]  prog_data = 8'h00;
    logic [3:0]  opcode;
    logic [7:0]  bus;
    logic [3:0]  pc_out;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic        carry;
    logic        halted;
    logic        bus_conflict;

    sap1_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .bus(bus), .pc_out(pc_out), .a_out(a_out),
        .b_out(b_out), .carry(carry), .halted(halted), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [11:0] ctrl;
        logic        we;
        logic [3:0]  wa;
        logic [7:0]  wd;
        logic [7:0]  bus;
        logic [3:0]  pc;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  op;
        logic        c;
        logic        h;
        logic        bc;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic [11:0] cw, input logic we,
                       input logic [3:0] wa, input logic [7:0] wd, input logic [7:0] eb,
                       input logic [3:0] pc, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic c, input logic h, input logic bc);
        vec_t v;
        v.rst = r; v.ctrl = cw; v.we = we; v.wa = wa; v.wd = wd; v.bus = eb;
        v.pc = pc; v.a = a; v.b = b; v.op = op; v.c = c; v.h = h; v.bc = bc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int step, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s step %0d: got %h required %h", name, step, act, req);
        end
    endtask

    // Watchdog: the bench must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t e;

        // Program load while held in reset (writes must land regardless of rst)
        add(1, 12'h000, 1, 4'h0, 8'h09, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'h1, 8'h1A, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'h2, 8'h2B, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'h3, 8'hF0, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'h9, 8'h10, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'hA, 8'h14, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(1, 12'h000, 1, 4'hB, 8'h04, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        // LDA 9
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h1, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h0C0, 0, 4'h0, 8'h00, 8'h09, 4'h1, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h120, 0, 4'h0, 8'h00, 8'h09, 4'h1, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h090, 0, 4'h0, 8'h00, 8'h10, 4'h1, 8'h10, 8'h00, 4'h0, 0, 0, 0);
        // ADD A
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h01, 4'h1, 8'h10, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h2, 8'h10, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h0C0, 0, 4'h0, 8'h00, 8'h1A, 4'h2, 8'h10, 8'h00, 4'h1, 0, 0, 0);
        add(0, 12'h120, 0, 4'h0, 8'h00, 8'h0A, 4'h2, 8'h10, 8'h00, 4'h1, 0, 0, 0);
        add(0, 12'h084, 0, 4'h0, 8'h00, 8'h14, 4'h2, 8'h10, 8'h14, 4'h1, 0, 0, 0);
        add(0, 12'h011, 0, 4'h0, 8'h00, 8'h24, 4'h2, 8'h24, 8'h14, 4'h1, 0, 0, 0);
        // SUB B
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h02, 4'h2, 8'h24, 8'h14, 4'h1, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h3, 8'h24, 8'h14, 4'h1, 0, 0, 0);
        add(0, 12'h0C0, 0, 4'h0, 8'h00, 8'h2B, 4'h3, 8'h24, 8'h14, 4'h2, 0, 0, 0);
        add(0, 12'h120, 0, 4'h0, 8'h00, 8'h0B, 4'h3, 8'h24, 8'h14, 4'h2, 0, 0, 0);
        add(0, 12'h084, 0, 4'h0, 8'h00, 8'h04, 4'h3, 8'h24, 8'h04, 4'h2, 0, 0, 0);
        add(0, 12'h013, 0, 4'h0, 8'h00, 8'h20, 4'h3, 8'h20, 8'h04, 4'h2, 0, 0, 0);
        // HLT
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h03, 4'h3, 8'h20, 8'h04, 4'h2, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h4, 8'h20, 8'h04, 4'h2, 0, 0, 0);
        add(0, 12'h0C0, 0, 4'h0, 8'h00, 8'hF0, 4'h4, 8'h20, 8'h04, 4'hF, 0, 0, 0);
        add(0, 12'h800, 0, 4'h0, 8'h00, 8'h00, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        // Halted: state frozen, bus still live, RAM write to [5] still lands
        add(0, 12'h400, 1, 4'h5, 8'h77, 8'h00, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        add(0, 12'h011, 0, 4'h0, 8'h00, 8'h24, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        add(0, 12'h011, 0, 4'h0, 8'h00, 8'h24, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        add(0, 12'h088, 0, 4'h0, 8'h00, 8'h20, 4'h4, 8'h20, 8'h04, 4'hF, 0, 1, 0);
        // Reset overrides ctrl and halt
        add(1, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        // Walk PC to 5, MAR <- 5, read back the word written while halted
        for (int i = 1; i <= 5; i++)
            add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'(i), 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h05, 4'h5, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h080, 0, 4'h0, 8'h00, 8'h77, 4'h5, 8'h00, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h090, 0, 4'h0, 8'h00, 8'h77, 4'h5, 8'h77, 8'h00, 4'h0, 0, 0, 0);
        // ADD wrap: A=FF, B=01 -> A=00, carry=1
        add(0, 12'h000, 1, 4'h6, 8'hFF, 8'h00, 4'h5, 8'h77, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h000, 1, 4'h7, 8'h01, 8'h00, 4'h5, 8'h77, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h6, 8'h77, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h06, 4'h6, 8'h77, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h090, 0, 4'h0, 8'h00, 8'hFF, 4'h6, 8'hFF, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h7, 8'hFF, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h07, 4'h7, 8'hFF, 8'h00, 4'h0, 0, 0, 0);
        add(0, 12'h084, 0, 4'h0, 8'h00, 8'h01, 4'h7, 8'hFF, 8'h01, 4'h0, 0, 0, 0);
        add(0, 12'h011, 0, 4'h0, 8'h00, 8'h00, 4'h7, 8'h00, 8'h01, 4'h0, 1, 0, 0);
        // SUB borrow: A=03, B=05 -> A=FE, carry=1
        add(0, 12'h000, 1, 4'h8, 8'h03, 8'h00, 4'h7, 8'h00, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h000, 1, 4'h9, 8'h05, 8'h00, 4'h7, 8'h00, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h8, 8'h00, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h08, 4'h8, 8'h00, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h090, 0, 4'h0, 8'h00, 8'h03, 4'h8, 8'h03, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'h9, 8'h03, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h300, 0, 4'h0, 8'h00, 8'h09, 4'h9, 8'h03, 8'h01, 4'h0, 1, 0, 0);
        add(0, 12'h084, 0, 4'h0, 8'h00, 8'h05, 4'h9, 8'h03, 8'h05, 4'h0, 1, 0, 0);
        add(0, 12'h013, 0, 4'h0, 8'h00, 8'hFE, 4'h9, 8'hFE, 8'h05, 4'h0, 1, 0, 0);
        // PC wrap 15 -> 0
        for (int i = 10; i <= 16; i++)
            add(0, 12'h400, 0, 4'h0, 8'h00, 8'h00, 4'(i % 16), 8'hFE, 8'h05, 4'h0, 1, 0, 0);
        // Bus conflict: A wins over MEM, flag sticks until reset
        add(0, 12'h088, 0, 4'h0, 8'h00, 8'hFE, 4'h0, 8'hFE, 8'h05, 4'h0, 1, 0, 1);
        add(0, 12'h000, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'hFE, 8'h05, 4'h0, 1, 0, 1);
        add(0, 12'h0A0, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'hFE, 8'h05, 4'h0, 1, 0, 1);
        add(1, 12'h000, 0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 4'h0, 0, 0, 0);

        // Main table: drive, check bus before the edge, score registers after
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            @(negedge clk);
            rst = v.rst; ctrl = v.ctrl;
            prog_we = v.we; prog_addr = v.wa; prog_data = v.wd;
            exp_q.push_back(v);
            #1;
            chk("bus", i, bus, v.bus);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk("pc", i, {4'h0, pc_out}, {4'h0, e.pc});
            chk("a", i, a_out, e.a);
            chk("b", i, b_out, e.b);
            chk("opcode", i, {4'h0, opcode}, {4'h0, e.op});
            chk("carry", i, {7'h00, carry}, {7'h00, e.c});
            chk("halted", i, {7'h00, halted}, {7'h00, e.h});
            chk("bus_conflict", i, {7'h00, bus_conflict}, {7'h00, e.bc});
        end

        // Hand sequence: program-load write collides with a MEM_EN read of the same address
        @(negedge clk);
        rst = 1'b0; prog_we = 1'b0; ctrl = 12'h400;
        for (int i = 0; i < 5; i++) @(negedge clk);
        ctrl = 12'h300;                      // MAR <- PC (5)
        @(negedge clk);
        ctrl = 12'h090; prog_we = 1'b1; prog_addr = 4'h5; prog_data = 8'h5A;
        #1;
        chk("collide_bus_old", 1000, bus, 8'h77);
        @(posedge clk);
        #1;
        chk("collide_a_old", 1001, a_out, 8'h77);
        @(negedge clk);
        prog_we = 1'b0; ctrl = 12'h090;
        #1;
        chk("collide_bus_new", 1002, bus, 8'h5A);
        @(posedge clk);
        #1;
        chk("collide_a_new", 1003, a_out, 8'h5A);
        chk("collide_pc", 1004, {4'h0, pc_out}, 8'h05);
        @(negedge clk);
        ctrl = 12'h000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
